// File: rtl/prime_req_arbiter.sv
// prime_req_arbiter: shares one prime-search engine among NREQ requesters.
// Round-robin grant, range check, engine start/wait, hang watchdog with
// engine recovery, and a one-cycle result pulse back to the granted requester.
module prime_req_arbiter #(
  parameter int NREQ    = 4,
  parameter int W       = 14,
  parameter int TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_intake,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   resp_valid,
  output logic [W-1:0]      resp_up,
  output logic [W-1:0]      resp_low,
  output logic              resp_err,
  output logic              busy,
  output logic              eng_reset,
  output logic              eng_give_valid,
  output logic [W-1:0]      eng_intake,
  input  logic [W-1:0]      eng_up,
  input  logic [W-1:0]      eng_low,
  input  logic              eng_out_valid
);

  localparam int              PW      = $clog2(NREQ);
  localparam logic [PW:0]     NREQ_W  = (PW+1)'(NREQ);
  localparam logic [PW-1:0]   LAST    = PW'(NREQ-1);
  localparam logic [15:0]     CNT_MAX = 16'(TIMEOUT-1);
  localparam logic [W-1:0]    LO_LIM  = W'(3);
  localparam logic [W-1:0]    HI_LIM  = W'(9972);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RECOVER,
    S_RESP
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [W-1:0]    intake_q, intake_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [W-1:0]    up_q, up_d;
  logic [W-1:0]    low_q, low_d;
  logic            err_q, err_d;
  logic            rec_q, rec_d;

  logic            gnt_any;
  logic [PW-1:0]   gnt_idx;
  logic [W-1:0]    gnt_intake;
  logic            in_range;

  // Round-robin pick: first asserted request scanning upward from rr_ptr
  always_comb begin
    logic [PW:0] sum;
    gnt_any = 1'b0;
    gnt_idx = '0;
    sum     = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, rr_ptr_q} + (PW+1)'(k);
      if (sum >= NREQ_W) sum = sum - NREQ_W;
      if (!gnt_any && req_valid[sum[PW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = sum[PW-1:0];
      end
    end
  end

  // Intake of the winning requester, sampled in the grant cycle
  always_comb begin
    gnt_intake = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (gnt_idx == PW'(k)) gnt_intake = req_intake[k*W +: W];
    end
    in_range = (gnt_intake >= LO_LIM) && (gnt_intake <= HI_LIM);
  end

  // Next-state and datapath updates for the request sequencer
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    intake_d = intake_q;
    cnt_d    = cnt_q;
    up_d     = up_q;
    low_d    = low_q;
    err_d    = err_q;
    rec_d    = rec_q;
    unique case (state_q)
      S_IDLE: begin
        if (gnt_any) begin
          owner_d  = gnt_idx;
          intake_d = gnt_intake;
          rr_ptr_d = (gnt_idx == LAST) ? '0 : gnt_idx + PW'(1);
          if (in_range) begin
            state_d = S_ISSUE;
          end else begin
            // Rejected without touching the engine
            up_d    = '0;
            low_d   = '0;
            err_d   = 1'b1;
            state_d = S_RESP;
          end
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 16'd1;
        // A result in the watchdog's last cycle still counts as success
        if (eng_out_valid) begin
          up_d    = eng_up;
          low_d   = eng_low;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (cnt_q == CNT_MAX) begin
          up_d    = '0;
          low_d   = '0;
          err_d   = 1'b1;
          rec_d   = 1'b0;
          state_d = S_RECOVER;
        end
      end
      S_RECOVER: begin
        // Two cycles of engine reset, tracked by rec_q
        rec_d = 1'b1;
        if (rec_q) state_d = S_RESP;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      intake_q <= '0;
      cnt_q    <= '0;
      up_q     <= '0;
      low_q    <= '0;
      err_q    <= 1'b0;
      rec_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      intake_q <= intake_d;
      cnt_q    <= cnt_d;
      up_q     <= up_d;
      low_q    <= low_d;
      err_q    <= err_d;
      rec_q    <= rec_d;
    end
  end

  // Per-requester handshake pulses; req_ready is held off while in reset
  for (genvar g = 0; g < NREQ; g++) begin : g_lane
    assign req_ready[g]  = reset_n && (state_q == S_IDLE) && gnt_any && (gnt_idx == PW'(g));
    assign resp_valid[g] = (state_q == S_RESP) && (owner_q == PW'(g));
  end

  // Shared outputs; result fields are zero outside the response cycle
  always_comb begin
    resp_up        = (state_q == S_RESP) ? up_q  : '0;
    resp_low       = (state_q == S_RESP) ? low_q : '0;
    resp_err       = (state_q == S_RESP) && err_q;
    busy           = (state_q != S_IDLE);
    eng_reset      = !reset_n || (state_q == S_RECOVER);
    eng_give_valid = (state_q == S_ISSUE);
    eng_intake     = intake_q;
  end

endmodule
